// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE configuration-bus target.
package redmule_pkg;

  localparam int unsigned REDMULE_REG_TRIGGER = 'h00;
  localparam int unsigned REDMULE_REG_STATUS  = 'h04;
  localparam int unsigned REDMULE_REG_CLEAR   = 'h08;
  localparam int unsigned REDMULE_CFG_BASE    = 'h40;

  localparam int unsigned REDMULE_STATUS_BUSY    = 0;
  localparam int unsigned REDMULE_STATUS_PENDING = 1;
  localparam int unsigned REDMULE_STATUS_DONE    = 2;
  localparam int unsigned REDMULE_STATUS_ERR     = 3;
  localparam int unsigned REDMULE_STATUS_CNT_LSB = 8;
  localparam int unsigned REDMULE_JOB_CNT_W      = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } redmule_cfg_target_state_e;

endpackage

// File: rtl/hwpe_ctrl_intf_periph.sv
// Peripheral request/response bus between the decoder master and a register target.
interface hwpe_ctrl_intf_periph #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 8
);
  logic                   req;
  logic [AddrWidth-1:0]   add;
  logic                   wen;
  logic [DataWidth/8-1:0] be;
  logic [DataWidth-1:0]   data;
  logic [IdWidth-1:0]     id;
  logic                   gnt;
  logic [DataWidth-1:0]   r_data;
  logic                   r_valid;
  logic [IdWidth-1:0]     r_id;

  modport master (output req, add, wen, be, data, id, input gnt, r_data, r_valid, r_id);
  modport slave  (input req, add, wen, be, data, id, output gnt, r_data, r_valid, r_id);
endinterface

// File: rtl/redmule_cfg_bank.sv
// Job register bank: byte-enable write port, per-register valid mask, bulk load.
module redmule_cfg_bank #(
  parameter int unsigned NumRegs   = 6,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdxW      = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
  input  logic                           clk_int,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           wr_en,
  input  logic [IdxW-1:0]                wr_idx,
  input  logic [DataWidth/8-1:0]         wr_be,
  input  logic [DataWidth-1:0]           wr_data,
  input  logic                           load_en,
  input  logic [NumRegs*DataWidth-1:0]   load_data,
  input  logic                           clr_mask,
  output logic [NumRegs*DataWidth-1:0]   regs_o,
  output logic [NumRegs-1:0]             valid_o
);

  localparam int unsigned BeW = DataWidth / 8;

  logic [NumRegs-1:0][DataWidth-1:0] regs_q;
  logic [NumRegs-1:0]                valid_q;

  // A bulk load marks every register as holding valid data.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q  <= '0;
      valid_q <= '0;
    end else if (clear_i) begin
      regs_q  <= '0;
      valid_q <= '0;
    end else begin
      if (clr_mask)     valid_q <= '0;
      else if (load_en) valid_q <= '1;
      if (load_en) begin
        regs_q <= load_data;
      end else if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
        for (int unsigned b = 0; b < BeW; b++) begin
          if (wr_be[b]) regs_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign regs_o  = regs_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/redmule_cfg_target.sv
// RedMulE configuration-bus responder: stages job registers, commits on trigger,
// queues one pending job behind the running one and reports status.
module redmule_cfg_target
  import redmule_pkg::*;
#(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned IdWidth    = 8,
  parameter int unsigned NumCfgRegs = 6,
  parameter int unsigned CfgBase    = REDMULE_CFG_BASE
) (
  input  logic                            clk_int,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  hwpe_ctrl_intf_periph.slave             periph,
  output logic                            cfg_complete_o,
  output logic                            start_o,
  output logic [NumCfgRegs*DataWidth-1:0] job_cfg_o,
  output logic                            busy_o,
  input  logic                            done_i,
  output logic                            evt_o
);

  localparam int unsigned IdxW    = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;
  localparam int unsigned CfgSpan = 4 * NumCfgRegs;

  redmule_cfg_target_state_e state_q;

  logic [NumCfgRegs-1:0][DataWidth-1:0] shadow_regs, pend_regs, job_cfg_q;
  logic [NumCfgRegs-1:0]                shadow_valid, pend_valid;
  logic                                 start_q, evt_q, done_sticky_q, err_sticky_q;
  logic [REDMULE_JOB_CNT_W-1:0]         job_cnt_q;
  logic                                 r_valid_q;
  logic [IdWidth-1:0]                   r_id_q;
  logic [DataWidth-1:0]                 r_data_q;

  logic                 run_c, pending_c, complete_c, wr_c;
  logic                 trig_hit_c, stat_hit_c, clr_hit_c, cfg_hit_c, unmapped_c;
  logic                 trig_wr_c, clr_wr_c, cfg_wr_c;
  logic                 commit_c, take_pend_c, trig_err_c, promote_c, chain_c;
  logic                 pend_load_c, shadow_clr_c;
  logic [AddrWidth-1:0] cfg_off_c;
  logic [IdxW-1:0]      cfg_idx_c;
  logic [DataWidth-1:0] status_c, rdata_c;

  // Address decode and job hand-off decisions for the current cycle.
  always_comb begin
    run_c        = (state_q == RUN);
    pending_c    = &pend_valid;
    complete_c   = &shadow_valid;
    wr_c         = periph.req & ~periph.wen;
    trig_hit_c   = (periph.add == AddrWidth'(REDMULE_REG_TRIGGER));
    stat_hit_c   = (periph.add == AddrWidth'(REDMULE_REG_STATUS));
    clr_hit_c    = (periph.add == AddrWidth'(REDMULE_REG_CLEAR));
    cfg_off_c    = periph.add - AddrWidth'(CfgBase);
    cfg_hit_c    = (periph.add >= AddrWidth'(CfgBase)) && (cfg_off_c < AddrWidth'(CfgSpan))
                   && (periph.add[1:0] == 2'b00);
    cfg_idx_c    = cfg_off_c[IdxW+1:2];
    unmapped_c   = periph.req && !(trig_hit_c || stat_hit_c || clr_hit_c || cfg_hit_c);
    trig_wr_c    = wr_c && trig_hit_c;
    clr_wr_c     = wr_c && clr_hit_c;
    cfg_wr_c     = wr_c && cfg_hit_c;
    commit_c     = !run_c && trig_wr_c && complete_c;
    take_pend_c  = run_c && trig_wr_c && complete_c && !pending_c;
    trig_err_c   = trig_wr_c && !commit_c && !take_pend_c;
    promote_c    = run_c && done_i && pending_c;
    chain_c      = run_c && done_i && !pending_c && take_pend_c;
    pend_load_c  = take_pend_c && !done_i;
    shadow_clr_c = commit_c || take_pend_c;

    status_c = '0;
    status_c[REDMULE_STATUS_BUSY]    = run_c;
    status_c[REDMULE_STATUS_PENDING] = pending_c;
    status_c[REDMULE_STATUS_DONE]    = done_sticky_q;
    status_c[REDMULE_STATUS_ERR]     = err_sticky_q;
    status_c[REDMULE_STATUS_CNT_LSB +: REDMULE_JOB_CNT_W] = job_cnt_q;

    rdata_c = '0;
    if (periph.req && periph.wen) begin
      if (stat_hit_c)     rdata_c = status_c;
      else if (cfg_hit_c) rdata_c = shadow_regs[cfg_idx_c];
    end
  end

  redmule_cfg_bank #(
    .NumRegs   (NumCfgRegs),
    .DataWidth (DataWidth),
    .IdxW      (IdxW)
  ) i_shadow (
    .clk_int   (clk_int),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .wr_en     (cfg_wr_c),
    .wr_idx    (cfg_idx_c),
    .wr_be     (periph.be),
    .wr_data   (periph.data),
    .load_en   (1'b0),
    .load_data ('0),
    .clr_mask  (shadow_clr_c),
    .regs_o    (shadow_regs),
    .valid_o   (shadow_valid)
  );

  // Pending buffer: its all-ones valid mask doubles as the pending flag.
  redmule_cfg_bank #(
    .NumRegs   (NumCfgRegs),
    .DataWidth (DataWidth),
    .IdxW      (IdxW)
  ) i_pending (
    .clk_int   (clk_int),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .wr_en     (1'b0),
    .wr_idx    ('0),
    .wr_be     ('0),
    .wr_data   ('0),
    .load_en   (pend_load_c),
    .load_data (shadow_regs),
    .clr_mask  (promote_c),
    .regs_o    (pend_regs),
    .valid_o   (pend_valid)
  );

  // Job FSM, sticky status, bus response.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      job_cfg_q     <= '0;
      start_q       <= 1'b0;
      evt_q         <= 1'b0;
      done_sticky_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      job_cnt_q     <= '0;
      r_valid_q     <= 1'b0;
      r_id_q        <= '0;
      r_data_q      <= '0;
    end else if (clear_i) begin
      state_q       <= IDLE;
      job_cfg_q     <= '0;
      start_q       <= 1'b0;
      evt_q         <= 1'b0;
      done_sticky_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      job_cnt_q     <= '0;
      r_valid_q     <= 1'b0;
      r_id_q        <= '0;
      r_data_q      <= '0;
    end else begin
      r_valid_q <= periph.req;
      r_data_q  <= rdata_c;
      if (periph.req) r_id_q <= periph.id;
      start_q <= 1'b0;
      evt_q   <= 1'b0;
      if (clr_wr_c) begin
        done_sticky_q <= 1'b0;
        err_sticky_q  <= 1'b0;
      end
      if (unmapped_c || trig_err_c) err_sticky_q <= 1'b1;
      if (run_c && done_i) begin
        done_sticky_q <= 1'b1;
        job_cnt_q     <= job_cnt_q + REDMULE_JOB_CNT_W'(1);
        evt_q         <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (commit_c) begin
            job_cfg_q <= shadow_regs;
            start_q   <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (promote_c) begin
            job_cfg_q <= pend_regs;
            start_q   <= 1'b1;
          end else if (chain_c) begin
            job_cfg_q <= shadow_regs;
            start_q   <= 1'b1;
          end else if (done_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign periph.gnt     = periph.req;
  assign periph.r_valid = r_valid_q;
  assign periph.r_id    = r_id_q;
  assign periph.r_data  = r_data_q;
  assign cfg_complete_o = complete_c;
  assign start_o        = start_q;
  assign job_cfg_o      = job_cfg_q;
  assign busy_o         = run_c;
  assign evt_o          = evt_q;

endmodule

// File: tb/tb_redmule_cfg_target.sv
// Directed bench for redmule_cfg_target: register-access vector table plus job-flow sequences.
module tb_redmule_cfg_target;

  logic           clk_int = 1'b0;
  logic           rst_ni;
  logic           clear_i;
  logic           done_i;
  logic           cfg_complete_o, start_o, busy_o, evt_o;
  logic [191:0]   job_cfg_o;

  int n_vec = 0;
  int n_err = 0;

  hwpe_ctrl_intf_periph #(.AddrWidth(32), .DataWidth(32), .IdWidth(8)) periph ();

  redmule_cfg_target dut (
    .clk_int        (clk_int),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .periph         (periph),
    .cfg_complete_o (cfg_complete_o),
    .start_o        (start_o),
    .job_cfg_o      (job_cfg_o),
    .busy_o         (busy_o),
    .done_i         (done_i),
    .evt_o          (evt_o)
  );

  always #5 clk_int = ~clk_int;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  id;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus access; returns at posedge+1 with the response visible.
  task automatic bus(input logic wen, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] data, input logic [7:0] id);
    periph.req  = 1'b1;
    periph.wen  = wen;
    periph.add  = addr;
    periph.be   = be;
    periph.data = data;
    periph.id   = id;
    @(posedge clk_int); #1;
    periph.req  = 1'b0;
    periph.wen  = 1'b1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus(1'b0, addr, 4'hF, data, 8'h00);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bus(1'b1, addr, 4'h0, 32'h0, 8'h00);
    data = periph.r_data;
  endtask

  task automatic stage(input logic [31:0] x);
    wr(32'h40, x);
    wr(32'h44, 32'h2000);
    wr(32'h48, 32'h3000);
    wr(32'h4C, 32'h0020_0010);
    wr(32'h50, 32'h20);
    wr(32'h54, 32'h480);
  endtask

  task automatic done_pulse();
    done_i = 1'b1;
    @(posedge clk_int); #1;
    done_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk_int); #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] rdat;
    vec_t v;

    vecs[0]  = '{1'b0, 32'h40,  4'hF, 32'h1111_2222, 8'h01, 32'h0};
    vecs[1]  = '{1'b1, 32'h40,  4'h0, 32'h0,         8'h02, 32'h1111_2222};
    vecs[2]  = '{1'b0, 32'h44,  4'hF, 32'h1111_2222, 8'h03, 32'h0};
    vecs[3]  = '{1'b0, 32'h44,  4'h3, 32'hAAAA_BBBB, 8'h5A, 32'h0};
    vecs[4]  = '{1'b1, 32'h44,  4'h0, 32'h0,         8'h5A, 32'h1111_BBBB};
    vecs[5]  = '{1'b0, 32'h48,  4'h8, 32'hCC00_0000, 8'h05, 32'h0};
    vecs[6]  = '{1'b1, 32'h48,  4'h0, 32'h0,         8'h06, 32'hCC00_0000};
    vecs[7]  = '{1'b1, 32'h04,  4'h0, 32'h0,         8'h07, 32'h0};
    vecs[8]  = '{1'b1, 32'h100, 4'h0, 32'h0,         8'h08, 32'h0};
    vecs[9]  = '{1'b1, 32'h04,  4'h0, 32'h0,         8'h09, 32'h8};
    vecs[10] = '{1'b0, 32'h08,  4'hF, 32'h0,         8'h0A, 32'h0};
    vecs[11] = '{1'b1, 32'h04,  4'h0, 32'h0,         8'h0B, 32'h0};
    vecs[12] = '{1'b0, 32'h00,  4'hF, 32'h0,         8'h0C, 32'h0};
    vecs[13] = '{1'b1, 32'h04,  4'h0, 32'h0,         8'h0D, 32'h8};
    vecs[14] = '{1'b1, 32'h00,  4'h0, 32'h0,         8'h0E, 32'h0};
    vecs[15] = '{1'b1, 32'h42,  4'h0, 32'h0,         8'h0F, 32'h0};
    vecs[16] = '{1'b0, 32'h54,  4'hF, 32'h480,       8'h10, 32'h0};
    vecs[17] = '{1'b1, 32'h54,  4'h0, 32'h0,         8'h11, 32'h480};
    vecs[18] = '{1'b0, 32'h58,  4'hF, 32'hDEAD_BEEF, 8'h12, 32'h0};
    vecs[19] = '{1'b1, 32'h58,  4'h0, 32'h0,         8'h13, 32'h0};

    rst_ni = 1'b0; clear_i = 1'b0; done_i = 1'b0;
    periph.req = 1'b0; periph.wen = 1'b1; periph.add = '0;
    periph.be = '0; periph.data = '0; periph.id = '0;
    @(posedge clk_int); #1;
    check("rst start_o", 32'(start_o), 32'h0);
    check("rst busy_o", 32'(busy_o), 32'h0);
    check("rst evt_o", 32'(evt_o), 32'h0);
    check("rst cfg_complete_o", 32'(cfg_complete_o), 32'h0);
    check("rst job_cfg_o[0]", job_cfg_o[31:0], 32'h0);
    check("rst r_valid", 32'(periph.r_valid), 32'h0);
    check("rst gnt", 32'(periph.gnt), 32'h0);
    rst_ni = 1'b1;

    // Register-access vectors
    for (int i = 0; i < 20; i++) begin
      v = vecs[i];
      bus(v.wen, v.addr, v.be, v.wdata, v.id);
      check($sformatf("vec%0d r_valid", i), 32'(periph.r_valid), 32'h1);
      check($sformatf("vec%0d r_id", i), 32'(periph.r_id), 32'(v.id));
      check($sformatf("vec%0d r_data", i), periph.r_data, v.exp_rdata);
    end

    // done_i in IDLE is ignored
    do_reset();
    done_pulse();
    check("idle done evt_o", 32'(evt_o), 32'h0);
    rd(32'h04, rdat);
    check("idle done status", rdat, 32'h0);

    // Full stage + trigger starts a job
    do_reset();
    stage(32'h1000);
    check("t1 complete before trig", 32'(cfg_complete_o), 32'h1);
    wr(32'h00, 32'h0);
    check("t1 start_o", 32'(start_o), 32'h1);
    check("t1 job_cfg[0]", job_cfg_o[31:0], 32'h1000);
    check("t1 job_cfg[5]", job_cfg_o[191:160], 32'h480);
    check("t1 busy_o", 32'(busy_o), 32'h1);
    check("t1 cfg_complete_o", 32'(cfg_complete_o), 32'h0);
    @(posedge clk_int); #1;
    check("t1 start_o falls", 32'(start_o), 32'h0);

    // Incomplete trigger raises err; CLEAR_STICKY drops it
    do_reset();
    wr(32'h40, 32'h1); wr(32'h44, 32'h2); wr(32'h48, 32'h3); wr(32'h4C, 32'h4); wr(32'h50, 32'h5);
    wr(32'h00, 32'h0);
    check("t2 no start", 32'(start_o), 32'h0);
    check("t2 not busy", 32'(busy_o), 32'h0);
    rd(32'h04, rdat);
    check("t2 status err", rdat, 32'h8);
    wr(32'h08, 32'h0);
    rd(32'h04, rdat);
    check("t2 status cleared", rdat, 32'h0);

    // Pending job promoted on done
    do_reset();
    stage(32'h1000); wr(32'h00, 32'h0);
    stage(32'h5000);
    check("t3 complete staged", 32'(cfg_complete_o), 32'h1);
    wr(32'h00, 32'h0);
    check("t3 no start on queue", 32'(start_o), 32'h0);
    check("t3 job_cfg held", job_cfg_o[31:0], 32'h1000);
    rd(32'h04, rdat);
    check("t3 status pending", rdat, 32'h3);
    done_pulse();
    check("t3 start_o", 32'(start_o), 32'h1);
    check("t3 evt_o", 32'(evt_o), 32'h1);
    check("t3 job_cfg[0]", job_cfg_o[31:0], 32'h5000);
    rd(32'h04, rdat);
    check("t3 status count", rdat, 32'h105);
    done_pulse();
    check("t3 idle after last", 32'(busy_o), 32'h0);

    // Trigger coincident with done, nothing pending
    do_reset();
    stage(32'h1000); wr(32'h00, 32'h0);
    stage(32'h7000);
    periph.req = 1'b1; periph.wen = 1'b0; periph.add = 32'h00; periph.be = 4'hF;
    periph.data = 32'h0; done_i = 1'b1;
    @(posedge clk_int); #1;
    periph.req = 1'b0; periph.wen = 1'b1; done_i = 1'b0;
    check("t4 start_o", 32'(start_o), 32'h1);
    check("t4 job_cfg[0]", job_cfg_o[31:0], 32'h7000);
    check("t4 busy_o", 32'(busy_o), 32'h1);
    check("t4 evt_o", 32'(evt_o), 32'h1);
    rd(32'h04, rdat);
    check("t4 status", rdat, 32'h105);

    // Async reset with a pending job
    do_reset();
    stage(32'h1000); wr(32'h00, 32'h0);
    stage(32'h5000); wr(32'h00, 32'h0);
    rst_ni = 1'b0;
    #1;
    check("t6 rst busy_o", 32'(busy_o), 32'h0);
    check("t6 rst job_cfg[0]", job_cfg_o[31:0], 32'h0);
    check("t6 rst start_o", 32'(start_o), 32'h0);
    @(posedge clk_int); #1;
    rst_ni = 1'b1;
    @(posedge clk_int); #1;
    check("t6 no start after rst", 32'(start_o), 32'h0);
    rd(32'h04, rdat);
    check("t6 status", rdat, 32'h0);

    // Soft clear mid-job
    stage(32'h1000); wr(32'h00, 32'h0);
    clear_i = 1'b1;
    @(posedge clk_int); #1;
    clear_i = 1'b0;
    check("clr busy_o", 32'(busy_o), 32'h0);
    check("clr job_cfg[0]", job_cfg_o[31:0], 32'h0);
    rd(32'h04, rdat);
    check("clr status", rdat, 32'h0);

    // Job counter wraps after 256 completions
    do_reset();
    for (int j = 0; j < 255; j++) begin
      stage(32'(j));
      wr(32'h00, 32'h0);
      done_pulse();
    end
    rd(32'h04, rdat);
    check("cnt 255", rdat, 32'hFF04);
    stage(32'h9000); wr(32'h00, 32'h0); done_pulse();
    rd(32'h04, rdat);
    check("cnt wrap", rdat, 32'h0004);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/redmule_cfg_target.md
Name: redmule_cfg_target

Overview:
Peripheral-side responder for the RedMulE configuration bus. It accepts the initiator's register writes (six job registers at 0x40..0x54, trigger at 0x00), stages them in shadow registers and commits them to the engine on trigger. One pending job can be queued behind a running one, and status is readable over the same bus. It sits between the instruction decoder's periph master port and the RedMulE controller/engine.

Parameters:
DataWidth, 32, periph data and register width
AddrWidth, 32, periph address width
IdWidth, 8, periph transaction id width
NumCfgRegs, 6, number of job registers (X ptr, W ptr, Z ptr, M|K, N, arith instr)
CfgBase, 'h40, byte offset of job register 0; register i is at CfgBase + 4*i

Ports:
clk_int  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
clear_i  in  1  synchronous soft clear, same effect as reset
periph  hwpe_ctrl_intf_periph.slave  -  req, add, wen (0 = write), be, data, id in; gnt, r_data, r_valid, r_id out
cfg_complete_o  out  1  all NumCfgRegs shadow registers written since the last commit
start_o  out  1  one-cycle pulse: job_cfg_o has just been loaded, engine must start
job_cfg_o  out  NumCfgRegs*DataWidth  committed job registers, stable while busy_o
busy_o  out  1  engine owns a committed job
done_i  in  1  one-cycle pulse from the engine: current job finished
evt_o  out  1  one-cycle pulse, registered copy of done_i

Behaviour:
- Reset/clear: shadow, committed, valid mask, pending and sticky bits = 0; all outputs 0; FSM = IDLE.
- Bus: gnt = req (combinational, never stalls). For each granted access, r_valid = 1 in the next cycle with r_id = the captured id; r_data = read value for reads and 0 for writes.
- Register map:
  - 0x00 TRIGGER: write = commit request; reads 0.
  - 0x04 STATUS (RO): bit0 busy, bit1 pending, bit2 done_sticky, bit3 err_sticky, bits[15:8] job count.
  - 0x08 CLEAR_STICKY: write clears bits 2 and 3.
  - CfgBase..CfgBase+4*(NumCfgRegs-1): shadow registers, RW.
  - Unmapped addresses: granted, write ignored, read returns 0, err_sticky set.
- Shadow write: byte lanes where be=1 are updated, and valid_mask[i] is set, even for partial be.
- cfg_complete_o = &valid_mask (combinational from register state).
- FSM has two states, IDLE and RUN.
  - IDLE, TRIGGER write with cfg_complete_o=1: next cycle copies shadow to committed, clears valid_mask, pulses start_o, goes to RUN.
  - IDLE, TRIGGER write with cfg_complete_o=0: ignored, err_sticky set.
  - RUN, TRIGGER write with complete mask and pending=0: snapshot shadow into the pending buffer, set pending, clear valid_mask.
  - RUN, TRIGGER write with pending=1 or an incomplete mask: ignored, err_sticky set.
  - RUN, done_i with pending=1: copy pending buffer to committed, clear pending, pulse start_o next cycle, stay in RUN.
  - RUN, done_i with pending=0: go to IDLE.
  - Every done_i: set done_sticky, increment job count (8-bit, wraps 255 -> 0), pulse evt_o next cycle.
- Simultaneous TRIGGER write and done_i in RUN with pending=0: the trigger is taken as a pending job and is promoted immediately, so start_o pulses next cycle and FSM stays in RUN.
- Simultaneous shadow write and TRIGGER: only one access per cycle on the bus, so this cannot occur.
- Write to the same shadow register after valid_mask is set: overwrites, no error.
- done_i in IDLE: ignored, and counters are not updated.
- busy_o = (state == RUN); job_cfg_o changes only on a start_o-producing cycle.
- Reset or clear mid-job drops the running and pending jobs; start_o is not emitted.

Decomposition:
- redmule_pkg gains:
  - REDMULE_REG_TRIGGER, REDMULE_REG_STATUS, REDMULE_REG_CLEAR offsets;
  - REDMULE_CFG_BASE;
  - STATUS bit index constants;
  - the redmule_cfg_target_state_e enum (IDLE, RUN).
- One sub-module, redmule_cfg_bank: NumCfgRegs x DataWidth register bank with byte-enable write, valid mask and bulk-copy load port, instantiated twice (shadow and pending).

Test Plan:
1. Write 0x1000, 0x2000, 0x3000, 0x00200010, 0x20, 0x480 to 0x40..0x54, then write 0x00 -> next cycle start_o=1, job_cfg_o[0]=0x1000, job_cfg_o[5]=0x480, busy_o=1, cfg_complete_o=0.
2. Write only 0x40..0x50, then TRIGGER -> no start_o, STATUS read = 0x8; write 0x08 -> STATUS = 0x0.
3. Job A running; stage B (X=0x5000) and trigger -> STATUS bit1=1; done_i -> start_o next cycle, job_cfg_o[0]=0x5000, evt_o=1, job count=1.
4. With RUN and pending=0, a TRIGGER write (complete mask, X=0x7000) coincides with done_i -> start_o next cycle with X=0x7000, busy_o stays 1.
5. Partial write be=4'b0011 data 0xAAAABBBB onto 0x44 holding 0x11112222 -> read 0x44 returns 0x1111BBBB; r_id echoes id 0x5A.
6. Assert rst_ni low during RUN with pending=1 -> all outputs 0, STATUS=0; 256 completed jobs -> job count wraps to 0.
